// File: rtl/nes_joypad_pkg.sv
// Shared definitions for the NES controller-port emulation.
// Button bit positions follow the order in which a real pad shifts them out.
package nes_joypad_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_COUNT  = 8;

    // Onboard button vector layout: {start, A}
    localparam int BOARD_A     = 0;
    localparam int BOARD_START = 1;

    // 10 Hz turbo toggle at the 21.428571 MHz NES system clock
    localparam int C_TURBO_DIV_DEFAULT = 2142857;

    typedef logic [BTN_COUNT-1:0] btn_vec_t;

    // Place the two onboard buttons at their pad bit positions
    function automatic btn_vec_t board_to_pad(input logic [1:0] board);
        btn_vec_t v;
        v            = '0;
        v[BTN_A]     = board[BOARD_A];
        v[BTN_START] = board[BOARD_START];
        return v;
    endfunction

endpackage

// File: rtl/joypad_shifter.sv
// One emulated 4021 shift register: parallel load while strobe is high,
// shift one bit per falling edge of the read clock, count reads up to 8.
module joypad_shifter
    import nes_joypad_pkg::*;
#(
    parameter logic C_FILL = 1'b1
)(
    input  logic       clock,
    input  logic       R_reset,
    input  logic       i_strobe,
    input  logic       i_joy_clock,
    input  btn_vec_t   i_load,
    output logic       o_data,
    output logic [3:0] o_count
);

    localparam logic [3:0] MAX_READS = 4'd8;

    btn_vec_t   r_shift;
    logic       r_last_clk;
    logic [3:0] r_count;
    logic       w_fall;

    assign w_fall = r_last_clk & ~i_joy_clock;

    // Remember the previous read-clock level so a high-to-low step can be seen
    always_ff @(posedge clock) begin
        if (R_reset) begin
            r_last_clk <= 1'b0;
        end else begin
            r_last_clk <= i_joy_clock;
        end
    end

    // Strobe reloads and clears the count; otherwise a falling edge shifts in the fill bit
    always_ff @(posedge clock) begin
        if (R_reset) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (i_strobe) begin
            r_shift <= i_load;
            r_count <= '0;
        end else if (w_fall) begin
            r_shift <= {C_FILL, r_shift[BTN_COUNT-1:1]};
            if (r_count != MAX_READS) begin
                r_count <= r_count + 4'd1;
            end
        end
    end

    assign o_data  = r_shift[0];
    assign o_count = r_count;

endmodule

// File: rtl/nes_joypad_port.sv
// Controller-port front end: synchronises the USB and onboard button vectors,
// merges them into player 1, optionally adds turbo, and feeds one shifter per pad.
// Optional: define JOYPAD_TURBO_EN to build the turbo auto-fire counter.
module nes_joypad_port
    import nes_joypad_pkg::*;
#(
    parameter int   C_PLAYERS   = 1,
    parameter int   C_TURBO_DIV = C_TURBO_DIV_DEFAULT,
    parameter logic C_FILL      = 1'b1
)(
    input  logic       clock,
    input  logic       R_reset,
    input  logic [7:0] i_usb_btn_p1,
    input  logic [7:0] i_usb_btn_p2,
    input  logic [1:0] i_board_btn,
    input  logic [1:0] i_turbo_p1,
    input  logic       i_joy_strobe,
    input  logic [1:0] i_joy_clock,
    output logic [1:0] o_joy_data,
    output logic [3:0] o_reads_p1
);

    btn_vec_t   r_p1_sync1;
    btn_vec_t   r_p1_sync2;
    btn_vec_t   r_p1_prev;
    btn_vec_t   r_p1_stable;
    logic [1:0] r_board_sync1;
    logic [1:0] r_board_sync2;
    logic [1:0] r_board_prev;
    logic [1:0] r_board_stable;
    btn_vec_t   w_turbo_terms;
    btn_vec_t   w_merged_p1;
    logic       w_data_p1;
    logic       w_data_p2;

    // Player-1 sources: two-flop sync, then accept only a vector seen twice in a row
    always_ff @(posedge clock) begin
        if (R_reset) begin
            r_p1_sync1     <= '0;
            r_p1_sync2     <= '0;
            r_p1_prev      <= '0;
            r_p1_stable    <= '0;
            r_board_sync1  <= '0;
            r_board_sync2  <= '0;
            r_board_prev   <= '0;
            r_board_stable <= '0;
        end else begin
            r_p1_sync1    <= i_usb_btn_p1;
            r_p1_sync2    <= r_p1_sync1;
            r_p1_prev     <= r_p1_sync2;
            r_board_sync1 <= i_board_btn;
            r_board_sync2 <= r_board_sync1;
            r_board_prev  <= r_board_sync2;
            if (r_p1_sync2 == r_p1_prev) begin
                r_p1_stable <= r_p1_sync2;
            end
            if (r_board_sync2 == r_board_prev) begin
                r_board_stable <= r_board_sync2;
            end
        end
    end

`ifdef JOYPAD_TURBO_EN
    localparam int TURBO_W = $clog2(C_TURBO_DIV + 1);

    logic [1:0]         r_turbo_sync1;
    logic [1:0]         r_turbo_sync2;
    logic [1:0]         r_turbo_prev;
    logic [1:0]         r_turbo_stable;
    logic [TURBO_W-1:0] r_turbo_cnt;
    logic               r_turbo_phase;

    // Turbo request crosses domains the same way as the button vectors
    always_ff @(posedge clock) begin
        if (R_reset) begin
            r_turbo_sync1  <= '0;
            r_turbo_sync2  <= '0;
            r_turbo_prev   <= '0;
            r_turbo_stable <= '0;
        end else begin
            r_turbo_sync1 <= i_turbo_p1;
            r_turbo_sync2 <= r_turbo_sync1;
            r_turbo_prev  <= r_turbo_sync2;
            if (r_turbo_sync2 == r_turbo_prev) begin
                r_turbo_stable <= r_turbo_sync2;
            end
        end
    end

    // Free-running divider that flips the auto-fire phase every C_TURBO_DIV cycles
    always_ff @(posedge clock) begin
        if (R_reset) begin
            r_turbo_cnt   <= '0;
            r_turbo_phase <= 1'b0;
        end else if (r_turbo_cnt == TURBO_W'(C_TURBO_DIV - 1)) begin
            r_turbo_cnt   <= '0;
            r_turbo_phase <= ~r_turbo_phase;
        end else begin
            r_turbo_cnt <= r_turbo_cnt + 1'b1;
        end
    end

    // Gate the requested turbo buttons with the current phase
    always_comb begin
        w_turbo_terms        = '0;
        w_turbo_terms[BTN_A] = r_turbo_stable[0] & r_turbo_phase;
        w_turbo_terms[BTN_B] = r_turbo_stable[1] & r_turbo_phase;
    end
`else
    logic w_unused_turbo;

    assign w_unused_turbo = ^i_turbo_p1;
    assign w_turbo_terms  = '0;
`endif

    assign w_merged_p1 = r_p1_stable | board_to_pad(r_board_stable) | w_turbo_terms;

    joypad_shifter #(
        .C_FILL (C_FILL)
    ) u_shifter_p1 (
        .clock       (clock),
        .R_reset     (R_reset),
        .i_strobe    (i_joy_strobe),
        .i_joy_clock (i_joy_clock[0]),
        .i_load      (w_merged_p1),
        .o_data      (w_data_p1),
        .o_count     (o_reads_p1)
    );

    generate
        if (C_PLAYERS >= 2) begin : g_player2
            btn_vec_t   r_p2_sync1;
            btn_vec_t   r_p2_sync2;
            btn_vec_t   r_p2_prev;
            btn_vec_t   r_p2_stable;
            logic [3:0] w_unused_reads_p2;

            // Player-2 USB vector: same sync-and-stability filter as player 1
            always_ff @(posedge clock) begin
                if (R_reset) begin
                    r_p2_sync1  <= '0;
                    r_p2_sync2  <= '0;
                    r_p2_prev   <= '0;
                    r_p2_stable <= '0;
                end else begin
                    r_p2_sync1 <= i_usb_btn_p2;
                    r_p2_sync2 <= r_p2_sync1;
                    r_p2_prev  <= r_p2_sync2;
                    if (r_p2_sync2 == r_p2_prev) begin
                        r_p2_stable <= r_p2_sync2;
                    end
                end
            end

            joypad_shifter #(
                .C_FILL (C_FILL)
            ) u_shifter_p2 (
                .clock       (clock),
                .R_reset     (R_reset),
                .i_strobe    (i_joy_strobe),
                .i_joy_clock (i_joy_clock[1]),
                .i_load      (r_p2_stable),
                .o_data      (w_data_p2),
                .o_count     (w_unused_reads_p2)
            );
        end else begin : g_no_player2
            logic w_unused_p2;

            assign w_unused_p2 = ^{i_usb_btn_p2, i_joy_clock[1]};
            assign w_data_p2   = 1'b0;
        end
    endgenerate

    assign o_joy_data = {w_data_p2, w_data_p1};

endmodule

// File: tb/tb_nes_joypad_port.sv
// Directed bench for nes_joypad_port with two pads and a short turbo divider.
`timescale 1ns/1ps
module tb_nes_joypad_port;

    logic       clock = 1'b0;
    logic       R_reset;
    logic [7:0] i_usb_btn_p1;
    logic [7:0] i_usb_btn_p2;
    logic [1:0] i_board_btn;
    logic [1:0] i_turbo_p1;
    logic       i_joy_strobe;
    logic [1:0] i_joy_clock;
    logic [1:0] o_joy_data;
    logic [3:0] o_reads_p1;

    int errorCount = 0;
    int checkCount = 0;

    typedef struct {
        logic       doEdge;
        logic [1:0] expData;
        logic [3:0] expReads;
    } readVec_t;

    readVec_t readTable[11];
    logic     turboSamples[24];

    nes_joypad_port #(
        .C_PLAYERS   (2),
        .C_TURBO_DIV (4),
        .C_FILL      (1'b1)
    ) dut (
        .clock        (clock),
        .R_reset      (R_reset),
        .i_usb_btn_p1 (i_usb_btn_p1),
        .i_usb_btn_p2 (i_usb_btn_p2),
        .i_board_btn  (i_board_btn),
        .i_turbo_p1   (i_turbo_p1),
        .i_joy_strobe (i_joy_strobe),
        .i_joy_clock  (i_joy_clock),
        .o_joy_data   (o_joy_data),
        .o_reads_p1   (o_reads_p1)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // One read-clock pulse on both pads: high for a cycle, then low
    task automatic applyStimulus(input logic doEdge);
        if (doEdge) begin
            i_joy_clock = 2'b11;
            step();
            i_joy_clock = 2'b00;
            step();
        end
    endtask

    task automatic strobePulse();
        i_joy_strobe = 1'b1;
        step();
        i_joy_strobe = 1'b0;
        step();
    endtask

    // Read eight player-1 bits, one per falling edge after the first
    task automatic readVector(input string name, input logic [7:0] expVec);
        checkOutput($sformatf("%s bit0", name), 8'(o_joy_data[0]), 8'(expVec[0]));
        for (int k = 1; k < 8; k++) begin
            applyStimulus(1'b1);
            checkOutput($sformatf("%s bit%0d", name, k), 8'(o_joy_data[0]), 8'(expVec[k]));
        end
    endtask

    initial begin
        int  firstEdge;
        logic expBit;

        // p1 = 8'h09 (USB A + board start), p2 = 8'hA5; data is {p2,p1}
        readTable[0]  = '{1'b0, 2'b11, 4'd0};
        readTable[1]  = '{1'b1, 2'b00, 4'd1};
        readTable[2]  = '{1'b1, 2'b10, 4'd2};
        readTable[3]  = '{1'b1, 2'b01, 4'd3};
        readTable[4]  = '{1'b1, 2'b00, 4'd4};
        readTable[5]  = '{1'b1, 2'b10, 4'd5};
        readTable[6]  = '{1'b1, 2'b00, 4'd6};
        readTable[7]  = '{1'b1, 2'b10, 4'd7};
        readTable[8]  = '{1'b1, 2'b11, 4'd8};
        readTable[9]  = '{1'b1, 2'b11, 4'd8};
        readTable[10] = '{1'b1, 2'b11, 4'd8};

        R_reset      = 1'b1;
        i_usb_btn_p1 = 8'h00;
        i_usb_btn_p2 = 8'h00;
        i_board_btn  = 2'b00;
        i_turbo_p1   = 2'b00;
        i_joy_strobe = 1'b0;
        i_joy_clock  = 2'b00;
        waitCycles(2);
        checkOutput("reset data", 8'(o_joy_data), 8'h00);
        checkOutput("reset reads", 8'(o_reads_p1), 8'h00);
        R_reset = 1'b0;

        // Merged snapshot, full read-out and fill bits
        i_usb_btn_p1 = 8'h01;
        i_board_btn  = 2'b10;
        i_usb_btn_p2 = 8'hA5;
        waitCycles(6);
        strobePulse();
        for (int i = 0; i < 11; i++) begin
            applyStimulus(readTable[i].doEdge);
            checkOutput($sformatf("read%0d data", i), 8'(o_joy_data), 8'(readTable[i].expData));
            checkOutput($sformatf("read%0d count", i), 8'(o_reads_p1), 8'(readTable[i].expReads));
        end

        // Live bit 0 while strobe is held and the vector changes to 8'h80
        i_board_btn  = 2'b00;
        i_usb_btn_p1 = 8'h00;
        waitCycles(6);
        i_joy_strobe = 1'b1;
        step();
        checkOutput("live start", 8'(o_joy_data[0]), 8'h00);
        i_usb_btn_p1 = 8'h80;
        for (int i = 0; i < 8; i++) begin
            step();
            checkOutput($sformatf("live %0d", i), 8'(o_joy_data[0]), 8'h00);
        end
        i_joy_strobe = 1'b0;
        step();
        readVector("live vec", 8'h80);

        // Strobe rising together with a falling read edge: load wins
        i_usb_btn_p1 = 8'h01;
        waitCycles(6);
        strobePulse();
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("pre-collide count", 8'(o_reads_p1), 8'h02);
        i_joy_clock = 2'b11;
        step();
        i_joy_clock  = 2'b00;
        i_joy_strobe = 1'b1;
        step();
        checkOutput("collide count", 8'(o_reads_p1), 8'h00);
        checkOutput("collide data", 8'(o_joy_data[0]), 8'h01);
        i_joy_strobe = 1'b0;
        step();
        checkOutput("after collide count", 8'(o_reads_p1), 8'h00);
        checkOutput("after collide data", 8'(o_joy_data[0]), 8'h01);

        // Toggling vector must not be accepted; settled 8'h10 must be
        i_joy_strobe = 1'b1;
        for (int i = 0; i < 20; i++) begin
            i_usb_btn_p1 = i[0] ? 8'hFF : 8'h00;
            step();
            checkOutput($sformatf("toggle hold %0d", i), 8'(o_joy_data[0]), 8'h01);
        end
        i_usb_btn_p1 = 8'h10;
        waitCycles(5);
        checkOutput("settled bit0", 8'(o_joy_data[0]), 8'h00);
        i_joy_strobe = 1'b0;
        step();
        readVector("settled vec", 8'h10);

        // Reset in the middle of a read sequence
        i_usb_btn_p1 = 8'hFF;
        waitCycles(6);
        strobePulse();
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("pre-reset data", 8'(o_joy_data[0]), 8'h01);
        checkOutput("pre-reset count", 8'(o_reads_p1), 8'h03);
        R_reset = 1'b1;
        step();
        checkOutput("mid reset data", 8'(o_joy_data), 8'h00);
        checkOutput("mid reset count", 8'(o_reads_p1), 8'h00);
        R_reset = 1'b0;
        waitCycles(6);
        strobePulse();
        readVector("post reset vec", 8'hFF);
        checkOutput("post reset count", 8'(o_reads_p1), 8'h07);

        // Turbo A with strobe held: 4 cycles on, 4 off when built in
        i_usb_btn_p1 = 8'h00;
        i_turbo_p1   = 2'b01;
        waitCycles(6);
        i_joy_strobe = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step();
            turboSamples[i] = o_joy_data[0];
        end
        i_joy_strobe = 1'b0;
`ifdef JOYPAD_TURBO_EN
        firstEdge = 0;
        for (int i = 8; i >= 1; i--) begin
            if (turboSamples[i] != turboSamples[i-1]) firstEdge = i;
        end
        checkOutput("turbo edge found", 8'(firstEdge != 0), 8'h01);
        if (firstEdge != 0) begin
            for (int j = firstEdge; j < firstEdge + 16; j++) begin
                expBit = turboSamples[firstEdge] ^ (((j - firstEdge) / 4) % 2 == 1);
                checkOutput($sformatf("turbo %0d", j), 8'(turboSamples[j]), 8'(expBit));
            end
        end
`else
        firstEdge = 0;
        expBit    = 1'b0;
        for (int i = 0; i < 24; i++) begin
            checkOutput($sformatf("turbo off %0d", i), 8'(turboSamples[i]), 8'(expBit));
        end
        checkOutput("turbo off edge", 8'(firstEdge), 8'h00);
`endif

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
